// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: prediction record layout,
// default fall-through offset and mispredict cause codes for debug display.
package branch_resolve_unit_pkg;

   localparam int PC_W = 32;
   localparam logic [PC_W-1:0] DEFAULT_FALLTHRU_OFS = 32'd8;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic            taken;
      logic [PC_W-1:0] target;
   } pred_rec_t;

   localparam int REC_W = $bits(pred_rec_t);

   typedef enum logic [2:0] {
      CAUSE_NONE,
      CAUSE_DIR,
      CAUSE_TGT,
      CAUSE_FALSE_TAKEN,
      CAUSE_SYNC
   } mispred_cause_t;

endpackage

// File: rtl/bru_pred_fifo.sv
// Circular buffer of in-flight prediction records between IF and ID.
// Clear has priority over push/pop so a redirect empties the buffer in one edge.
module bru_pred_fifo
   import branch_resolve_unit_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input  logic      CLK,
   input  logic      RESET,
   input  logic      push,
   input  logic      pop,
   input  logic      clear,
   input  pred_rec_t wr_data,
   output pred_rec_t rd_data,
   output logic      full,
   output logic      empty
);

   pred_rec_t        mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == (PTR_W + 1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // A full buffer still accepts a push when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[head];

   always_ff @(posedge CLK) begin
      if (do_push) begin
         mem[tail] <= wr_data;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (clear) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_push) tail <= next_ptr(tail);
         if (do_pop)  head <= next_ptr(head);
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Compares buffered IF predictions against ID outcomes, redirects fetch on a
// mispredict, trains the predictor and keeps branch statistics.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int          DEPTH        = 8,
   parameter int          PTR_W        = 3,
   parameter logic [31:0] FALLTHRU_OFS = DEFAULT_FALLTHRU_OFS
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        STALL,
   input  logic        push_valid,
   input  logic [31:0] push_pc,
   input  logic        push_taken,
   input  logic [31:0] push_target,
   input  logic        id_valid,
   input  logic [31:0] id_pc,
   input  logic        is_branch,
   input  logic        is_taken,
   input  logic        is_link,
   input  logic [31:0] alt_address,
   output logic        flush,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        upd_valid,
   output logic [31:0] upd_pc,
   output logic [31:0] upd_target,
   output logic        upd_taken,
   output logic        upd_link,
   output logic [31:0] br_count,
   output logic [31:0] mispred_count,
   output logic        sync_err,
   output logic        overflow
);

   pred_rec_t   wr_rec;
   pred_rec_t   head_rec;
   logic        fifo_full;
   logic        fifo_empty;
   logic        push_fire;
   logic        pop_fire;
   logic        head_match;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        mispredict;
   logic [31:0] correct_pc;

   assign push_fire = push_valid && !STALL && !flush;
   assign pop_fire  = id_valid && !STALL && !flush;
   assign wr_rec    = '{pc: push_pc, taken: push_taken, target: push_target};

   bru_pred_fifo #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_fifo (
      .CLK     (CLK),
      .RESET   (RESET),
      .push    (push_fire),
      .pop     (pop_fire),
      .clear   (mispredict),
      .wr_data (wr_rec),
      .rd_data (head_rec),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // An empty buffer or a tag mismatch both fall back to a not-taken prediction.
   always_comb begin
      head_match  = !fifo_empty && (head_rec.pc == id_pc);
      pred_taken  = 1'b0;
      pred_target = '0;
      if (head_match) begin
         pred_taken  = head_rec.taken;
         pred_target = head_rec.target;
      end
      mispredict = pop_fire &&
                   ((is_branch && (is_taken != pred_taken)) ||
                    (is_branch && is_taken && (alt_address != pred_target)) ||
                    (!is_branch && pred_taken));
      correct_pc = (is_branch && is_taken) ? alt_address : id_pc + FALLTHRU_OFS;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         flush       <= 1'b0;
         redirect    <= 1'b0;
         redirect_pc <= '0;
      end else begin
         flush    <= mispredict;
         redirect <= mispredict;
         if (mispredict) redirect_pc <= correct_pc;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         upd_valid  <= 1'b0;
         upd_pc     <= '0;
         upd_target <= '0;
         upd_taken  <= 1'b0;
         upd_link   <= 1'b0;
      end else begin
         upd_valid <= pop_fire && is_branch;
         if (pop_fire && is_branch) begin
            upd_pc     <= id_pc;
            upd_target <= alt_address;
            upd_taken  <= is_taken;
            upd_link   <= is_link;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         br_count      <= '0;
         mispred_count <= '0;
         sync_err      <= 1'b0;
         overflow      <= 1'b0;
      end else begin
         if (pop_fire && is_branch) br_count <= br_count + 1'b1;
         if (mispredict)            mispred_count <= mispred_count + 1'b1;
         if (pop_fire && !fifo_empty && !head_match) sync_err <= 1'b1;
         if (push_fire && fifo_full && !pop_fire)    overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: a queue-based reference model
// pushes expected outputs each cycle, which the scenario tasks pop and compare.
module tb_branch_resolve_unit;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        STALL = 1'b0;
   logic        push_valid = 1'b0;
   logic [31:0] push_pc = '0;
   logic        push_taken = 1'b0;
   logic [31:0] push_target = '0;
   logic        id_valid = 1'b0;
   logic [31:0] id_pc = '0;
   logic        is_branch = 1'b0;
   logic        is_taken = 1'b0;
   logic        is_link = 1'b0;
   logic [31:0] alt_address = '0;
   logic        flush, redirect, upd_valid, upd_taken, upd_link, sync_err, overflow;
   logic [31:0] redirect_pc, upd_pc, upd_target, br_count, mispred_count;

   always #5 CLK = ~CLK;

   branch_resolve_unit dut (
      .CLK(CLK), .RESET(RESET), .STALL(STALL),
      .push_valid(push_valid), .push_pc(push_pc), .push_taken(push_taken), .push_target(push_target),
      .id_valid(id_valid), .id_pc(id_pc), .is_branch(is_branch), .is_taken(is_taken),
      .is_link(is_link), .alt_address(alt_address),
      .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
      .upd_taken(upd_taken), .upd_link(upd_link),
      .br_count(br_count), .mispred_count(mispred_count),
      .sync_err(sync_err), .overflow(overflow)
   );

   typedef struct {
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
   } rec_t;

   typedef struct {
      logic        flush;
      logic [31:0] redirect_pc;
      logic        upd_valid;
      logic [31:0] upd_pc;
      logic [31:0] upd_target;
      logic        upd_taken;
      logic        upd_link;
      logic [31:0] br_count;
      logic [31:0] mispred_count;
      logic        sync_err;
      logic        overflow;
   } exp_t;

   rec_t        m_fifo[$];
   exp_t        exp_q[$];
   logic        m_flush, m_upd_valid, m_upd_taken, m_upd_link, m_sync, m_ovf;
   logic [31:0] m_rpc, m_upd_pc, m_upd_target, m_br, m_mis;
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic model_reset();
      m_fifo.delete();
      exp_q.delete();
      m_flush = 0; m_upd_valid = 0; m_upd_taken = 0; m_upd_link = 0; m_sync = 0; m_ovf = 0;
      m_rpc = '0; m_upd_pc = '0; m_upd_target = '0; m_br = '0; m_mis = '0;
   endtask

   // Reference model for one clock: predicts the outputs visible after the next edge.
   task automatic step();
      bit          push_ok, pop_ok, hit, pt, mis, did_pop;
      logic [31:0] ptg, cpc;
      exp_t        e;
      rec_t        r;
      push_ok = push_valid && !STALL && !m_flush;
      pop_ok  = id_valid && !STALL && !m_flush;
      hit     = pop_ok && (m_fifo.size() > 0) && (m_fifo[0].pc == id_pc);
      pt      = hit ? m_fifo[0].taken : 1'b0;
      ptg     = hit ? m_fifo[0].target : 32'h0;
      did_pop = pop_ok && (m_fifo.size() > 0);
      if (did_pop && !hit) m_sync = 1;
      mis = pop_ok && ((is_branch && (is_taken != pt)) ||
                       (is_branch && is_taken && (alt_address != ptg)) ||
                       (!is_branch && pt));
      cpc = (is_branch && is_taken) ? alt_address : id_pc + 32'd8;
      if (push_ok && (m_fifo.size() == 8) && !did_pop) m_ovf = 1;
      if (mis) m_fifo.delete();
      else begin
         if (did_pop) void'(m_fifo.pop_front());
         if (push_ok && (m_fifo.size() < 8)) begin
            r.pc = push_pc; r.taken = push_taken; r.target = push_target;
            m_fifo.push_back(r);
         end
      end
      m_flush = mis;
      if (mis) begin m_rpc = cpc; m_mis = m_mis + 1; end
      m_upd_valid = pop_ok && is_branch;
      if (pop_ok && is_branch) begin
         m_br = m_br + 1; m_upd_pc = id_pc; m_upd_target = alt_address;
         m_upd_taken = is_taken; m_upd_link = is_link;
      end
      e.flush = m_flush; e.redirect_pc = m_rpc; e.upd_valid = m_upd_valid; e.upd_pc = m_upd_pc;
      e.upd_target = m_upd_target; e.upd_taken = m_upd_taken; e.upd_link = m_upd_link;
      e.br_count = m_br; e.mispred_count = m_mis; e.sync_err = m_sync; e.overflow = m_ovf;
      exp_q.push_back(e);
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      push_valid = 0; id_valid = 0; is_branch = 0; is_taken = 0; is_link = 0; STALL = 0;
   endtask

   task automatic set_push(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      push_valid = 1; push_pc = pc; push_taken = tk; push_target = tgt;
   endtask

   task automatic set_pop(input logic [31:0] pc, input logic br, input logic tk,
                          input logic lnk, input logic [31:0] alt);
      id_valid = 1; id_pc = pc; is_branch = br; is_taken = tk; is_link = lnk; alt_address = alt;
   endtask

   task automatic test_reset();
      RESET = 0;
      idle();
      model_reset();
      #1;
      n_checks++; if (flush !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_flush: got %0b want 0", flush); end
      n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_redirect: got %0b want 0", redirect); end
      n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rpc: got %0h want 0", redirect_pc); end
      n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_upd_valid: got %0b want 0", upd_valid); end
      n_checks++; if ({br_count, mispred_count} !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_counters: got %0h/%0h want 0/0", br_count, mispred_count); end
      n_checks++; if ({sync_err, overflow} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_flags: got %0b%0b want 00", sync_err, overflow); end
      @(negedge CLK);
      RESET = 1;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_correct_predict();
      exp_t e;
      idle(); set_push(32'h100, 1, 32'h200); step(); void'(exp_q.pop_front());
      idle(); step(); void'(exp_q.pop_front());
      idle(); set_pop(32'h100, 1, 1, 0, 32'h200); step(); e = exp_q.pop_front();
      n_checks++; if (flush !== e.flush || flush !== 1'b0) begin n_fail++; $display("[TB] FAIL hit_flush: got %0b want %0b", flush, e.flush); end
      n_checks++; if (upd_valid !== 1'b1 || upd_pc !== e.upd_pc) begin n_fail++; $display("[TB] FAIL hit_upd: got v=%0b pc=%0h want v=1 pc=%0h", upd_valid, upd_pc, e.upd_pc); end
      n_checks++; if (br_count !== e.br_count || mispred_count !== e.mispred_count) begin n_fail++; $display("[TB] FAIL hit_counts: got %0d/%0d want %0d/%0d", br_count, mispred_count, e.br_count, e.mispred_count); end
      idle(); step(); e = exp_q.pop_front();
      n_checks++; if (upd_valid !== e.upd_valid) begin n_fail++; $display("[TB] FAIL hit_upd_pulse: got %0b want %0b", upd_valid, e.upd_valid); end
   endtask

   task automatic test_mispredict();
      exp_t e;
      idle(); set_push(32'h104, 0, 32'h0); step(); void'(exp_q.pop_front());
      idle(); set_pop(32'h104, 1, 1, 1, 32'h400); step(); e = exp_q.pop_front();
      n_checks++; if (flush !== 1'b1 || redirect !== 1'b1) begin n_fail++; $display("[TB] FAIL dir_flush: got %0b%0b want 11", flush, redirect); end
      n_checks++; if (redirect_pc !== 32'h400) begin n_fail++; $display("[TB] FAIL dir_rpc: got %0h want 400", redirect_pc); end
      n_checks++; if (mispred_count !== e.mispred_count || upd_link !== 1'b1) begin n_fail++; $display("[TB] FAIL dir_mis: got %0d link=%0b want %0d link=1", mispred_count, upd_link, e.mispred_count); end
      idle(); step(); e = exp_q.pop_front();
      n_checks++; if (flush !== 1'b0 || redirect !== 1'b0) begin n_fail++; $display("[TB] FAIL dir_one_cycle: got %0b%0b want 00", flush, redirect); end
      idle(); set_push(32'h108, 1, 32'h300); step(); void'(exp_q.pop_front());
      idle(); set_pop(32'h108, 0, 0, 0, 32'h0); step(); e = exp_q.pop_front();
      n_checks++; if (flush !== 1'b1 || redirect_pc !== 32'h110) begin n_fail++; $display("[TB] FAIL false_taken: got f=%0b pc=%0h want f=1 pc=110", flush, redirect_pc); end
      n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL false_taken_upd: got %0b want 0", upd_valid); end
      idle(); step(); void'(exp_q.pop_front());
   endtask

   task automatic test_overflow();
      exp_t e;
      for (int i = 0; i < 9; i++) begin
         idle(); set_push(32'h1000 + 32'(4 * i), 0, 32'h0); step(); e = exp_q.pop_front();
         if (i == 7 || i == 8) begin
            n_checks++; if (overflow !== e.overflow) begin n_fail++; $display("[TB] FAIL ovf_push%0d: got %0b want %0b", i, overflow, e.overflow); end
         end
      end
      idle(); set_push(32'h2000, 0, 32'h0); set_pop(32'h1000, 0, 0, 0, 32'h0); step(); e = exp_q.pop_front();
      n_checks++; if (flush !== 1'b0 || overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL full_pushpop: got f=%0b o=%0b want f=0 o=1", flush, overflow); end
      for (int i = 1; i < 9; i++) begin
         idle(); set_pop((i == 8) ? 32'h2000 : 32'h1000 + 32'(4 * i), 0, 0, 0, 32'h0); step(); e = exp_q.pop_front();
         n_checks++; if (flush !== e.flush || sync_err !== e.sync_err) begin n_fail++; $display("[TB] FAIL drain%0d: got f=%0b s=%0b want f=%0b s=%0b", i, flush, sync_err, e.flush, e.sync_err); end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      // STALL must block both push and pop; the popped instruction then sees an empty buffer.
      idle(); STALL = 1; set_push(32'h700, 1, 32'h800); set_pop(32'h6fc, 1, 1, 0, 32'h900); step(); void'(exp_q.pop_front());
      idle(); set_pop(32'h700, 0, 0, 0, 32'h0); step(); e = exp_q.pop_front();
      n_checks++; if (flush !== 1'b0 || br_count !== e.br_count) begin n_fail++; $display("[TB] FAIL stall: got f=%0b br=%0d want f=0 br=%0d", flush, br_count, e.br_count); end
      idle(); set_push(32'h900, 1, 32'ha00); set_pop(32'h8fc, 0, 0, 0, 32'h0); step(); e = exp_q.pop_front();
      n_checks++; if (flush !== 1'b0 || sync_err !== e.sync_err) begin n_fail++; $display("[TB] FAIL empty_pop: got f=%0b s=%0b want f=0 s=%0b", flush, sync_err, e.sync_err); end
      idle(); set_pop(32'h900, 1, 1, 0, 32'ha00); step(); e = exp_q.pop_front();
      n_checks++; if (flush !== 1'b0 || upd_target !== 32'ha00) begin n_fail++; $display("[TB] FAIL b2b_hit: got f=%0b t=%0h want f=0 t=a00", flush, upd_target); end
      idle(); set_push(32'hb00, 0, 32'h0); set_pop(32'hb00, 1, 1, 0, 32'hc00); step(); void'(exp_q.pop_front());
      idle(); set_push(32'hd00, 1, 32'he00); set_pop(32'hd00, 1, 1, 0, 32'he00); step(); e = exp_q.pop_front();
      n_checks++; if (flush !== 1'b0 || br_count !== e.br_count) begin n_fail++; $display("[TB] FAIL flush_ignores: got f=%0b br=%0d want f=0 br=%0d", flush, br_count, e.br_count); end
      idle(); set_push(32'h504, 0, 32'h0); step(); void'(exp_q.pop_front());
      idle(); set_pop(32'h500, 1, 1, 0, 32'h600); step(); e = exp_q.pop_front();
      n_checks++; if (sync_err !== 1'b1 || flush !== 1'b1 || redirect_pc !== 32'h600) begin n_fail++; $display("[TB] FAIL sync: got s=%0b f=%0b pc=%0h want s=1 f=1 pc=600", sync_err, flush, redirect_pc); end
      idle(); step(); void'(exp_q.pop_front());
   endtask

   task automatic test_random();
      exp_t e;
      for (int c = 0; c < 300; c++) begin
         idle();
         STALL = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 1) == 1) set_push(32'h100 + 32'(4 * $urandom_range(0, 7)), 1'($urandom_range(0, 1)), 32'h200 + 32'(4 * $urandom_range(0, 3)));
         if ($urandom_range(0, 2) != 0)
            set_pop((m_fifo.size() > 0 && $urandom_range(0, 7) != 0) ? m_fifo[0].pc : 32'h100 + 32'(4 * $urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h200 + 32'(4 * $urandom_range(0, 3)));
         step();
         e = exp_q.pop_front();
         n_checks++;
         if (flush !== e.flush || redirect !== e.flush || (e.flush && redirect_pc !== e.redirect_pc) ||
             upd_valid !== e.upd_valid || (e.upd_valid && {upd_pc, upd_target, upd_taken, upd_link} !== {e.upd_pc, e.upd_target, e.upd_taken, e.upd_link}) ||
             br_count !== e.br_count || mispred_count !== e.mispred_count || sync_err !== e.sync_err || overflow !== e.overflow) begin
            n_fail++;
            $display("[TB] FAIL rand%0d: got f=%0b pc=%0h u=%0b br=%0d mis=%0d s=%0b o=%0b want f=%0b pc=%0h u=%0b br=%0d mis=%0d s=%0b o=%0b",
                     c, flush, redirect_pc, upd_valid, br_count, mispred_count, sync_err, overflow,
                     e.flush, e.redirect_pc, e.upd_valid, e.br_count, e.mispred_count, e.sync_err, e.overflow);
         end
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      idle(); set_push(32'h104, 0, 32'h0); step(); void'(exp_q.pop_front());
      idle(); set_pop(32'h104, 1, 1, 0, 32'h400); step(); e = exp_q.pop_front();
      n_checks++; if (flush !== e.flush || flush !== 1'b1) begin n_fail++; $display("[TB] FAIL pre_reset_flush: got %0b want 1", flush); end
      idle();
      #2 RESET = 0;
      #1;
      model_reset();
      n_checks++; if (flush !== 1'b0 || redirect !== 1'b0) begin n_fail++; $display("[TB] FAIL areset_flush: got %0b%0b want 00", flush, redirect); end
      n_checks++; if (br_count !== 32'h0 || mispred_count !== 32'h0) begin n_fail++; $display("[TB] FAIL areset_counters: got %0d/%0d want 0/0", br_count, mispred_count); end
      @(negedge CLK);
      RESET = 1;
      @(posedge CLK);
      #1;
      idle(); set_pop(32'h104, 0, 0, 0, 32'h0); step(); e = exp_q.pop_front();
      n_checks++; if (flush !== 1'b0 || sync_err !== 1'b0) begin n_fail++; $display("[TB] FAIL areset_empty: got f=%0b s=%0b want f=0 s=0", flush, sync_err); end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_correct_predict();
      test_mispredict();
      test_overflow();
      test_back_to_back();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Resolution end of the fetch-prediction path. IF pushes one prediction record per fetched instruction; ID pops one record per decoded instruction and reports the real outcome.
- The block compares prediction against outcome. It drives flush plus redirect to IF and emits a training update to the predictor.
- Sits between the IF/predictor side and ID. It spans the multi-stage gap between them, so it buffers in-flight predictions.

Parameters:
- DEPTH, 8: prediction records held; must be at least the IF-to-ID stage count plus 1.
- PTR_W, 3: log2(DEPTH).
- FALLTHRU_OFS, 8: not-taken correct PC offset from the branch PC (branch plus delay slot).

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-low reset
- STALL  in  1  pipeline freeze; no push and no pop while high
- push_valid  in  1  IF fetched an instruction this cycle
- push_pc  in  32  PC of the fetched instruction
- push_taken  in  1  predictor said taken
- push_target  in  32  predicted target
- id_valid  in  1  ID holds a valid instruction this cycle
- id_pc  in  32  PC of the instruction in ID
- is_branch  in  1  ID instruction is a branch or jump
- is_taken  in  1  actual direction
- is_link  in  1  branch writes the link register
- alt_address  in  32  actual target
- flush  out  1  squash IF-to-ID stages
- redirect  out  1  IF must load redirect_pc
- redirect_pc  out  32  correct fetch PC
- upd_valid  out  1  predictor training strobe
- upd_pc, upd_target  out  32  branch PC and actual target
- upd_taken, upd_link  out  1  actual direction and link flag
- br_count, mispred_count  out  32  statistics
- sync_err, overflow  out  1  sticky error flags

Behaviour:
- Reset (RESET low, async): FIFO empty, pointers 0. All outputs 0: flush, redirect, redirect_pc, upd_*, both counters, sync_err, overflow. A reset during a pending flush cancels that flush.
- Push: push_valid and !STALL and !flush writes {pc, taken, target} at the tail. If full and no pop in the same cycle, the record is dropped and overflow is set (sticky).
- Pop: id_valid and !STALL and !flush pops the head. Push and pop in the same cycle are legal, including when full or empty (an empty pop does not consume the same-cycle push).
- Effective prediction on pop:
  - head matches (head.pc == id_pc): use head.taken and head.target.
  - empty: predicted not-taken, no error.
  - tag mismatch: predicted not-taken, sync_err set (sticky).
- Mispredict condition, evaluated combinationally in the pop cycle, any of:
  - is_branch and is_taken differs from pred_taken;
  - is_branch and is_taken and alt_address differs from pred_target;
  - not is_branch and pred_taken.
- Correct PC: alt_address when is_branch and is_taken; otherwise id_pc + FALLTHRU_OFS, mod 2^32.
- Latency: mispredict in cycle t gives flush=1, redirect=1 and redirect_pc=correct PC registered in cycle t+1, for exactly one cycle. At the same edge the FIFO pointers and count clear to empty.
- During the flush cycle, pushes and pops are ignored. STALL does not hold a pending flush; flush always lasts exactly one cycle.
- Update: every pop with is_branch gives upd_valid=1 in t+1 (one cycle) with upd_pc=id_pc, upd_taken=is_taken, upd_target=alt_address, upd_link=is_link.
- Counters:
  - br_count increments on every branch pop.
  - mispred_count increments on every mispredict.
  - Both wrap mod 2^32.
- A single cycle may both update and flush; both outputs assert together.

Decomposition:
- Shared include: record field widths, FALLTHRU_OFS default, mispredict cause encodings (DIR, TGT, FALSE_TAKEN, SYNC) for debug display.
- One sub-module: bru_pred_fifo, a DEPTH-entry circular buffer with push/pop/clear, full/empty, and wrapping pointers plus a count.
- Compare, redirect and counter logic stay in branch_resolve_unit.

Test Plan:
- Push pc=0x100 taken=1 target=0x200; later pop id_pc=0x100, is_branch=1, is_taken=1, alt=0x200 -> no flush; upd_valid next cycle with upd_pc=0x100; br_count=1; mispred_count=0.
- Push pc=0x104 taken=0; pop with is_taken=1, alt=0x400 -> next cycle flush=redirect=1, redirect_pc=0x400 for one cycle; FIFO empty; mispred_count=1.
- Push pc=0x108 taken=1 target=0x300; pop with is_branch=0 -> redirect_pc=0x110; no upd_valid.
- Push 8 records with no pop, then a 9th -> 9th dropped, overflow=1. Next, push and pop in the same cycle while full -> accepted, no new overflow.
- Pop id_pc=0x500 while head.pc=0x504, branch taken to 0x600 -> sync_err=1, flush, redirect_pc=0x600.
- Drive RESET low asynchronously in the cycle after a mispredict -> flush and redirect drop immediately, counters read 0, FIFO empty.
